plotter_pixel_scheduler: RTL

Sequences the pen plotter through a stored binary image. Reads 1-bit pixels from the image BRAM in raster order and presents each one on the plotter's `pixel_value_in`. Advances to the next pixel on each rising edge of the plotter's `ready_next_pixel`, and gates the plotter's `enable_plotter`. Sits between the image buffer, filled by the capture/threshold path, and `plotter_control`.

---
 rtl/plotter_pixel_scheduler_if.sv | 14 +
 rtl/plotter_pixel_scheduler.sv | 70 +++++++
 2 files changed

// File: rtl/plotter_pixel_scheduler_if.sv
// plotter_pixel_scheduler_if: signal bundle between the pixel scheduler, image BRAM and plotter
interface plotter_pixel_scheduler_if #(parameter int ADDR_W = 14);
    logic start, pause, ready_next_pixel, plotter_done, bram_data;
    logic [ADDR_W-1:0] bram_addr, pixel_idx;
    logic pixel_value_out, enable_plotter, busy, done;
    modport master(
        output start, pause, ready_next_pixel, plotter_done, bram_data,
        input bram_addr, pixel_idx, pixel_value_out, enable_plotter, busy, done
    );
    modport slave(
        input start, pause, ready_next_pixel, plotter_done, bram_data,
        output bram_addr, pixel_idx, pixel_value_out, enable_plotter, busy, done
    );
endinterface

// File: rtl/plotter_pixel_scheduler.sv
// plotter_pixel_scheduler: walks the image BRAM in raster order and feeds one pixel per plotter ready edge
module plotter_pixel_scheduler #(
    parameter int IMG_W = 80,
    parameter int IMG_H = 106,
    parameter int ADDR_W = 14,
    parameter int READ_LAT = 2
) (
    input logic clk_65mhz,
    input logic rst,
    plotter_pixel_scheduler_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, RUN, DRAIN, DONE} state_t;
    state_t state, state_d;
    logic [1:0] lat, lat_d;
    logic ready_q, started, started_d, rise, go;
    logic [ADDR_W-1:0] idx_d, addr_d;
    logic pix_d, en_d, busy_d, done_d;
    assign rise = bus.ready_next_pixel & ~ready_q;
    assign go = bus.start & (state == IDLE || state == DONE);
    always_ff @(posedge clk_65mhz) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: state_d = bus.start ? FETCH : state;
            FETCH:      state_d = WAIT_DATA;
            WAIT_DATA:  state_d = (lat == '0) ? RUN : WAIT_DATA;
            RUN:        state_d = bus.plotter_done ? DONE : !rise ? RUN : (bus.pixel_idx < LAST) ? FETCH : DRAIN;
            DRAIN:      state_d = bus.plotter_done ? DONE : DRAIN;
            default:    state_d = IDLE;
        endcase
    end
    // started remembers that RUN was reached, so a refetch keeps the plotter enabled
    always_comb begin
        lat_d = (state == FETCH) ? 2'(READ_LAT) : (state == WAIT_DATA && lat != '0) ? lat - 2'd1 : lat;
        idx_d = go ? '0 : (state == RUN && state_d == FETCH) ? bus.pixel_idx + ADDR_W'(1) : bus.pixel_idx;
        addr_d = (state == FETCH) ? bus.pixel_idx : bus.bram_addr;
        pix_d = (state == WAIT_DATA && lat == '0) ? bus.bram_data : (state_d == DRAIN) ? 1'b0 : bus.pixel_value_out;
        started_d = (state_d == RUN) | (started & (state_d inside {FETCH, WAIT_DATA, DRAIN}));
        en_d = ~bus.pause & ((state_d inside {RUN, DRAIN}) | (started & (state_d inside {FETCH, WAIT_DATA})));
        busy_d = state_d inside {FETCH, WAIT_DATA, RUN, DRAIN};
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            lat <= '0;
            ready_q <= 1'b0;
            started <= 1'b0;
            bus.pixel_idx <= '0;
            bus.bram_addr <= '0;
            bus.pixel_value_out <= 1'b0;
            bus.enable_plotter <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            lat <= lat_d;
            ready_q <= bus.ready_next_pixel;
            started <= started_d;
            bus.pixel_idx <= idx_d;
            bus.bram_addr <= addr_d;
            bus.pixel_value_out <= pix_d;
            bus.enable_plotter <= en_d;
            bus.busy <= busy_d;
            bus.done <= done_d;
        end
    end
endmodule
